// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: storage geometry and reader FSM state.
// Imported by the read-side consumer and the FIFO storage benches.
package fifo_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT,
    HOLD
  } reader_state_t;

endpackage

// File: rtl/fifo_reader.sv
// Read-side FIFO consumer: pulses ren, captures the RAM's registered
// read data and holds it on a valid/ready port until the sink takes it.
module fifo_reader #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              empty,
  input  logic [DATA_W-1:0] rdData,
  output logic              ren,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  rd_count
);

  import fifo_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  reader_state_t     r_state;
  logic              r_ren;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_count;

  // r_ren is set exactly on entry to READ, so it mirrors that state
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_ren   <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      r_ren <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (enable && !empty) begin
            r_state <= READ;
            r_ren   <= 1'b1;
          end
        end
        READ: begin
          r_state <= WAIT;
        end
        WAIT: begin
          r_data  <= rdData;
          r_valid <= 1'b1;
          r_state <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_count <= r_count + CNT_ONE;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ren       = r_ren;
  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign rd_count  = r_count;

endmodule
